// File: rtl/cpc_joy_pkg.sv
// Shared bit/column indices, matrix rows and SOCD/matrix helpers for the CPC joystick injector.
package cpc_joy_pkg;

  localparam logic [3:0] ROW_JOY1 = 4'd9;
  localparam logic [3:0] ROW_JOY2 = 4'd6;

  typedef enum logic [2:0] {
    B_UP, B_DOWN, B_LEFT, B_RIGHT, B_FIRE1, B_FIRE2, B_FIRE3, B_START
  } pad_bit_e;

  typedef enum logic [2:0] {
    C_UP, C_DOWN, C_LEFT, C_RIGHT, C_FIRE2, C_FIRE1, C_SPARE6, C_SPARE7
  } col_bit_e;

  // Opposing directions cancel each other out (active-high in, active-high out).
  function automatic logic [7:0] socd_resolve(input logic [7:0] act);
    logic [7:0] r;
    r = act;
    if (act[B_UP] && act[B_DOWN]) begin
      r[B_UP]   = 1'b0;
      r[B_DOWN] = 1'b0;
    end
    if (act[B_LEFT] && act[B_RIGHT]) begin
      r[B_LEFT]  = 1'b0;
      r[B_RIGHT] = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [7:0] pad_to_cols(input logic [7:0] pad_n);
    logic [7:0] c;
    c          = 8'hFF;
    c[C_UP]    = pad_n[B_UP];
    c[C_DOWN]  = pad_n[B_DOWN];
    c[C_LEFT]  = pad_n[B_LEFT];
    c[C_RIGHT] = pad_n[B_RIGHT];
    c[C_FIRE2] = pad_n[B_FIRE2];
    c[C_FIRE1] = pad_n[B_FIRE1];
    return c;
  endfunction

endpackage

// File: rtl/joy_debounce.sv
// One pad bit: 2-FF synchroniser preset to released, tick-sampled run counter, stable level.
module joy_debounce #(
  parameter int DEB_TICKS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic din_n,
  output logic dout_n
);

  logic [1:0] sync_reg;
  logic [3:0] run_cnt_reg;
  logic       stable_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg    <= 2'b11;
      run_cnt_reg <= '0;
      stable_reg  <= 1'b1;
    end else begin
      sync_reg <= {sync_reg[0], din_n};
      if (tick) begin
        if (sync_reg[1] != stable_reg) begin
          // Accept on the DEB_TICKS-th consecutive differing sample.
          if (run_cnt_reg == 4'(DEB_TICKS - 1)) begin
            stable_reg  <= sync_reg[1];
            run_cnt_reg <= '0;
          end else begin
            run_cnt_reg <= run_cnt_reg + 4'd1;
          end
        end else begin
          run_cnt_reg <= '0;
        end
      end
    end
  end

  assign dout_n = stable_reg;

endmodule

// File: rtl/joy_cpc_matrix.sv
// Debounces two active-low pads, resolves SOCD and injects them into CPC keyboard rows 9 and 6.
// Optional autofire on fire3 is enabled by defining JOY_AUTOFIRE_EN.
import cpc_joy_pkg::*;

module joy_cpc_matrix #(
  parameter int TICK_DIV  = 4000,
  parameter int DEB_TICKS = 4,
  parameter int AF_TICKS  = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] joy1_n,
  input  logic [7:0] joy2_n,
  input  logic [3:0] kb_row,
  output logic [7:0] kb_col_n,
  output logic [7:0] joy1_cln_n,
  output logic [7:0] joy2_cln_n,
  output logic       joy_any
);

  logic [15:0]     tick_cnt_reg;
  logic            tick;
  logic [15:0]     raw_n;
  logic [15:0]     stable_n;
  logic [1:0][7:0] cln_n;
  logic [7:0]      kb_col_reg;

  assign tick = (tick_cnt_reg == 16'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst)       tick_cnt_reg <= '0;
    else if (tick) tick_cnt_reg <= '0;
    else           tick_cnt_reg <= tick_cnt_reg + 16'd1;
  end

  assign raw_n = {joy2_n, joy1_n};

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_deb
      joy_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick),
        .din_n  (raw_n[gi]),
        .dout_n (stable_n[gi])
      );
    end

    for (gi = 0; gi < 2; gi++) begin : g_pad
      logic [7:0] act;
      logic [7:0] res;
      logic [7:0] cln_n_reg;
      logic       af_fire;

      assign act = ~stable_n[gi*8 +: 8];

`ifdef JOY_AUTOFIRE_EN
      logic [7:0] af_cnt_reg;
      logic       af_on_reg;

      // Square wave restarts in its active phase whenever fire3 is not held.
      always_ff @(posedge clk) begin
        if (rst || !act[B_FIRE3]) begin
          af_cnt_reg <= '0;
          af_on_reg  <= 1'b1;
        end else if (tick) begin
          if (af_cnt_reg == 8'(AF_TICKS - 1)) begin
            af_cnt_reg <= '0;
            af_on_reg  <= ~af_on_reg;
          end else begin
            af_cnt_reg <= af_cnt_reg + 8'd1;
          end
        end
      end

      assign af_fire = act[B_FIRE3] & af_on_reg;
`else
      assign af_fire = 1'b0;
`endif

      always_comb begin
        res           = socd_resolve(act);
        res[B_FIRE1]  = res[B_FIRE1] | af_fire;
      end

      always_ff @(posedge clk) begin
        if (rst) cln_n_reg <= 8'hFF;
        else     cln_n_reg <= ~res;
      end

      assign cln_n[gi] = cln_n_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      kb_col_reg <= 8'hFF;
    end else begin
      case (kb_row)
        ROW_JOY1: kb_col_reg <= pad_to_cols(cln_n[0]);
        ROW_JOY2: kb_col_reg <= pad_to_cols(cln_n[1]);
        default:  kb_col_reg <= 8'hFF;
      endcase
    end
  end

  assign kb_col_n   = kb_col_reg;
  assign joy1_cln_n = cln_n[0];
  assign joy2_cln_n = cln_n[1];
  // start (bit 7) is not a direction or fire bit.
  assign joy_any    = (cln_n[0][6:0] != 7'h7F) || (cln_n[1][6:0] != 7'h7F);

endmodule

// File: tb/tb_joy_cpc_matrix.sv
// Scoreboard bench for joy_cpc_matrix (TICK_DIV=4, DEB_TICKS=3, AF_TICKS=2); honours JOY_AUTOFIRE_EN.
module tb_joy_cpc_matrix;

  localparam int TICK_DIV  = 4;
  localparam int DEB_TICKS = 3;
  localparam int AF_TICKS  = 2;
  localparam int SETTLE    = DEB_TICKS * TICK_DIV + 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] joy1_n = 8'hFF;
  logic [7:0] joy2_n = 8'hFF;
  logic [3:0] kb_row = 4'd0;
  logic [7:0] kb_col_n;
  logic [7:0] joy1_cln_n;
  logic [7:0] joy2_cln_n;
  logic       joy_any;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;

  always #5 clk = ~clk;

  joy_cpc_matrix #(
    .TICK_DIV (TICK_DIV),
    .DEB_TICKS(DEB_TICKS),
    .AF_TICKS (AF_TICKS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .joy1_n     (joy1_n),
    .joy2_n     (joy2_n),
    .kb_row     (kb_row),
    .kb_col_n   (kb_col_n),
    .joy1_cln_n (joy1_cln_n),
    .joy2_cln_n (joy2_cln_n),
    .joy_any    (joy_any)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for a column value; the caller compares whatever is present afterwards.
  task automatic wait_col(input logic [7:0] target, input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (kb_col_n === target) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    joy1_n = 8'h00;
    joy2_n = 8'h00;
    repeat (3) step();
    for (int r = 0; r < 16; r++) begin
      kb_row = 4'(r);
      exp_q.push_back(8'hFF);
      step();
      exp_v = exp_q.pop_front();
      total++;
      if (kb_col_n !== exp_v) begin
        bad++;
        $display("FAIL reset_col row=%0d got=%h exp=%h", r, kb_col_n, exp_v);
      end else $display("txn reset row=%0d col=%h", r, kb_col_n);
      total++;
      if (joy1_cln_n !== 8'hFF) begin
        bad++;
        $display("FAIL reset_cln1 row=%0d got=%h exp=ff", r, joy1_cln_n);
      end
      total++;
      if (joy2_cln_n !== 8'hFF) begin
        bad++;
        $display("FAIL reset_cln2 row=%0d got=%h exp=ff", r, joy2_cln_n);
      end
      total++;
      if (joy_any !== 1'b0) begin
        bad++;
        $display("FAIL reset_any row=%0d got=%b exp=0", r, joy_any);
      end
    end
    joy1_n = 8'hFF;
    joy2_n = 8'hFF;
    rst = 1'b0;
    step();
  endtask

  task automatic test_up();
    logic [3:0] r;
    joy1_n = 8'hFE;
    kb_row = 4'd9;
    exp_q.push_back(8'hFE);
    wait_col(8'hFE, SETTLE);
    exp_v = exp_q.pop_front();
    total++;
    if (kb_col_n !== exp_v) begin
      bad++;
      $display("FAIL up_col got=%h exp=%h", kb_col_n, exp_v);
    end else $display("txn up row=9 col=%h", kb_col_n);
    total++;
    if (joy1_cln_n !== 8'hFE) begin
      bad++;
      $display("FAIL up_cln1 got=%h exp=fe", joy1_cln_n);
    end
    total++;
    if (joy_any !== 1'b1) begin
      bad++;
      $display("FAIL up_any got=%b exp=1", joy_any);
    end
    // Row changes every clock: output must follow one cycle behind.
    for (int i = 0; i < 13; i++) begin
      r = (i % 3 == 0) ? 4'd6 : (i % 3 == 1) ? 4'd9 : 4'(i);
      kb_row = r;
      exp_q.push_back((r == 4'd9) ? 8'hFE : 8'hFF);
      step();
      exp_v = exp_q.pop_front();
      total++;
      if (kb_col_n !== exp_v) begin
        bad++;
        $display("FAIL row_track row=%0d got=%h exp=%h", r, kb_col_n, exp_v);
      end else $display("txn track row=%0d col=%h", r, kb_col_n);
    end
    joy1_n = 8'hFF;
    repeat (SETTLE) step();
    total++;
    if (joy1_cln_n !== 8'hFF) begin
      bad++;
      $display("FAIL up_release got=%h exp=ff", joy1_cln_n);
    end
    total++;
    if (joy_any !== 1'b0) begin
      bad++;
      $display("FAIL up_release_any got=%b exp=0", joy_any);
    end
  endtask

  task automatic test_glitch();
    kb_row = 4'd6;
    joy2_n = 8'hDF;
    repeat (TICK_DIV) step();
    joy2_n = 8'hFF;
    for (int i = 0; i < 30; i++) begin
      exp_q.push_back(8'hFF);
      step();
      exp_v = exp_q.pop_front();
      total++;
      if (kb_col_n !== exp_v || joy2_cln_n !== 8'hFF) begin
        bad++;
        $display("FAIL glitch cyc=%0d col=%h cln2=%h exp=%h/ff", i, kb_col_n, joy2_cln_n, exp_v);
      end
    end
    $display("txn glitch col=%h cln2=%h", kb_col_n, joy2_cln_n);
  endtask

  task automatic test_socd();
    logic [7:0] stim [5];
    logic [7:0] ecol [5];
    logic [7:0] ecln [5];
    stim = '{8'hFC, 8'hF4, 8'hF3, 8'hF6, 8'hFF};
    ecol = '{8'hFF, 8'hF7, 8'hFF, 8'hF6, 8'hFF};
    ecln = '{8'hFF, 8'hF7, 8'hFF, 8'hF6, 8'hFF};
    kb_row = 4'd9;
    for (int i = 0; i < 5; i++) begin
      joy1_n = stim[i];
      repeat (SETTLE) step();
      exp_q.push_back(ecol[i]);
      exp_v = exp_q.pop_front();
      total++;
      if (kb_col_n !== exp_v) begin
        bad++;
        $display("FAIL socd_col in=%h got=%h exp=%h", stim[i], kb_col_n, exp_v);
      end else $display("txn socd in=%h col=%h", stim[i], kb_col_n);
      total++;
      if (joy1_cln_n !== ecln[i]) begin
        bad++;
        $display("FAIL socd_cln in=%h got=%h exp=%h", stim[i], joy1_cln_n, ecln[i]);
      end
      total++;
      if (joy_any !== (ecln[i][6:0] != 7'h7F)) begin
        bad++;
        $display("FAIL socd_any in=%h got=%b", stim[i], joy_any);
      end
    end
  endtask

  task automatic test_fire3();
    kb_row = 4'd9;
    joy1_n = 8'hBF;
`ifdef JOY_AUTOFIRE_EN
    exp_q.push_back(8'hDF);
    wait_col(8'hDF, SETTLE);
    exp_v = exp_q.pop_front();
    total++;
    if (kb_col_n !== exp_v || joy1_cln_n !== 8'hAF) begin
      bad++;
      $display("FAIL af_start col=%h cln1=%h exp=%h/af", kb_col_n, joy1_cln_n, exp_v);
    end else $display("txn af_start col=%h", kb_col_n);
    // Half-period is AF_TICKS*TICK_DIV = 8 clocks.
    for (int i = 0; i < 23; i++) begin
      exp_q.push_back((i < 7 || i >= 15) ? 8'hDF : 8'hFF);
      step();
      exp_v = exp_q.pop_front();
      total++;
      if (kb_col_n !== exp_v) begin
        bad++;
        $display("FAIL af_wave cyc=%0d got=%h exp=%h", i, kb_col_n, exp_v);
      end else $display("txn af_wave cyc=%0d col=%h", i, kb_col_n);
    end
`else
    repeat (SETTLE) step();
    total++;
    if (joy1_cln_n !== 8'hBF || joy_any !== 1'b1) begin
      bad++;
      $display("FAIL fire3_cln got=%h any=%b exp=bf/1", joy1_cln_n, joy_any);
    end
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'hFF);
      step();
      exp_v = exp_q.pop_front();
      total++;
      if (kb_col_n !== exp_v) begin
        bad++;
        $display("FAIL fire3_col cyc=%0d got=%h exp=%h", i, kb_col_n, exp_v);
      end
    end
    $display("txn fire3 col=%h cln1=%h", kb_col_n, joy1_cln_n);
`endif
    joy1_n = 8'hFF;
    repeat (SETTLE) step();
    total++;
    if (joy1_cln_n !== 8'hFF) begin
      bad++;
      $display("FAIL fire3_release got=%h exp=ff", joy1_cln_n);
    end
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'hFF);
      step();
      exp_v = exp_q.pop_front();
      total++;
      if (kb_col_n !== exp_v) begin
        bad++;
        $display("FAIL fire3_idle cyc=%0d got=%h exp=%h", i, kb_col_n, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    kb_row = 4'd6;
    joy2_n = 8'hFE;
    // At most two qualifying ticks can occur in this window.
    repeat (9) step();
    total++;
    if (joy2_cln_n !== 8'hFF) begin
      bad++;
      $display("FAIL mid_pre got=%h exp=ff", joy2_cln_n);
    end
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    // Fresh debounce: sync 2 clk, ticks at R4/R8/R12, cleaned at R13, column at R14.
    for (int i = 1; i <= 14; i++) begin
      exp_q.push_back((i >= 13) ? 8'hFE : 8'hFF);
      step();
      exp_v = exp_q.pop_front();
      total++;
      if (joy2_cln_n !== exp_v) begin
        bad++;
        $display("FAIL mid_cln2 R%0d got=%h exp=%h", i, joy2_cln_n, exp_v);
      end else $display("txn mid R%0d cln2=%h", i, joy2_cln_n);
    end
    total++;
    if (kb_col_n !== 8'hFE) begin
      bad++;
      $display("FAIL mid_col got=%h exp=fe", kb_col_n);
    end
    joy2_n = 8'hFF;
    repeat (SETTLE) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_up();
    test_glitch();
    test_socd();
    test_fire3();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
